// File: rtl/ram_responder.sv
// Memory-side responder: 512-byte big-endian RAM answering MFA byte/halfword/word
// requests with a four-phase MFA/MOC handshake and WAIT_CYCLES wait states.
module ram_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  mfa,
  input  logic                  rw,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  logic [7:0] memory [DEPTH];

  state_t                state;
  logic [3:0]            cnt;
  logic                  req_rw;
  logic [1:0]            req_mode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;

  logic                  acc_rw;
  logic [1:0]            acc_mode;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] addr_b1;
  logic [ADDR_WIDTH-1:0] addr_b2;
  logic [ADDR_WIDTH-1:0] addr_b3;
  logic [31:0]           acc_data;
  logic [31:0]           rd_data;
  logic                  acc_now;

  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [1:0] m,
                                                       input logic [ADDR_WIDTH-1:0] a);
    case (m)
      2'b00:   return a;
      2'b01:   return {a[ADDR_WIDTH-1:1], 1'b0};
      default: return {a[ADDR_WIDTH-1:2], 2'b00};
    endcase
  endfunction

  // With zero wait states the access happens on the sampling edge, so the live
  // request inputs feed the access path; otherwise the latched request does.
  always_comb begin
    if (state == S_IDLE) begin
      acc_rw   = rw;
      acc_mode = mode;
      acc_addr = align_addr(mode, address);
      acc_data = data_in;
    end else begin
      acc_rw   = req_rw;
      acc_mode = req_mode;
      acc_addr = req_addr;
      acc_data = req_data;
    end
  end

  assign addr_b1 = {acc_addr[ADDR_WIDTH-1:1], 1'b1};
  assign addr_b2 = {acc_addr[ADDR_WIDTH-1:2], 2'b10};
  assign addr_b3 = {acc_addr[ADDR_WIDTH-1:2], 2'b11};

  assign acc_now = reset && ((state == S_IDLE && mfa && ZERO_WAIT) ||
                             (state == S_WAIT && cnt == 4'd1));

  always_comb begin
    rd_data = '0;
    case (acc_mode)
      2'b00:   rd_data[7:0]  = memory[acc_addr];
      2'b01:   rd_data[15:0] = {memory[acc_addr], memory[addr_b1]};
      default: rd_data       = {memory[acc_addr], memory[addr_b1],
                                memory[addr_b2], memory[addr_b3]};
    endcase
  end

  // Request capture: data-path registers, no reset needed
  always_ff @(posedge main_clk) begin
    if (state == S_IDLE && mfa) begin
      req_rw   <= rw;
      req_mode <= mode;
      req_addr <= align_addr(mode, address);
      req_data <= data_in;
    end
  end

  // Array write: only the bytes selected by the access mode change
  always_ff @(posedge main_clk) begin
    if (acc_now && !acc_rw) begin
      case (acc_mode)
        2'b00: memory[acc_addr] <= acc_data[7:0];
        2'b01: begin
          memory[acc_addr] <= acc_data[15:8];
          memory[addr_b1]  <= acc_data[7:0];
        end
        default: begin
          memory[acc_addr] <= acc_data[31:24];
          memory[addr_b1]  <= acc_data[23:16];
          memory[addr_b2]  <= acc_data[15:8];
          memory[addr_b3]  <= acc_data[7:0];
        end
      endcase
    end
  end

  // Handshake FSM with registered moc/data_out
  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      moc      <= 1'b0;
      data_out <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mfa) begin
            if (ZERO_WAIT) begin
              moc   <= 1'b1;
              state <= S_DONE;
              if (rw) data_out <= rd_data;
            end else begin
              cnt   <= WAIT_LD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            moc   <= 1'b1;
            state <= S_DONE;
            if (req_rw) data_out <= rd_data;
          end
        end
        S_DONE: begin
          if (!mfa) begin
            moc   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: handshake latency, endianness, alignment,
// byte-lane writes, top-of-array access, early mfa drop and mid-access reset.
module tb_ram_responder;

  logic        main_clk;
  logic        reset;
  logic        mfa;
  logic        rw;
  logic [1:0]  mode;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;

  int n_cmp;
  int n_bad;

  ram_responder #(.ADDR_WIDTH(9), .DEPTH(512), .WAIT_CYCLES(2)) dut (
    .main_clk (main_clk),
    .reset    (reset),
    .mfa      (mfa),
    .rw       (rw),
    .mode     (mode),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // One full four-phase transaction; reports edges to moc and moc after mfa drops.
  task automatic xfer(input logic r, input logic [1:0] m, input logic [8:0] a,
                      input logic [31:0] d, output int lat, output logic moc_after);
    mfa = 1'b1; rw = r; mode = m; address = a; data_in = d;
    lat = 0;
    do begin
      @(posedge main_clk); #1;
      lat++;
    end while (!moc && lat < 20);
    mfa = 1'b0;
    @(posedge main_clk); #1;
    moc_after = moc;
  endtask

  task automatic test_reset();
    reset = 1'b0; mfa = 1'b0; rw = 1'b0; mode = 2'b00; address = '0; data_in = '0;
    repeat (2) @(posedge main_clk);
    #1;
    n_cmp++; if (moc !== 1'b0) begin n_bad++; $display("FAIL reset_moc got %b want 0", moc); end
    n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 00000000", data_out); end
    reset = 1'b1;
    @(posedge main_clk); #1;
  endtask

  task automatic preload();
    int lat; logic ma;
    xfer(1'b0, 2'b10, 9'd8,  32'hDEADBEEF, lat, ma);
    xfer(1'b0, 2'b10, 9'd12, 32'hAABBCCDD, lat, ma);
    xfer(1'b0, 2'b10, 9'd16, 32'h11223344, lat, ma);
    xfer(1'b0, 2'b00, 9'd0,  32'h00000077, lat, ma);
  endtask

  task automatic test_word_read();
    int lat; logic ma;
    xfer(1'b1, 2'b10, 9'd8, 32'h0, lat, ma);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL word_read_latency got %0d want 3", lat); end
    n_cmp++; if (data_out !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_read_data got %h want deadbeef", data_out); end
    n_cmp++; if (ma !== 1'b0) begin n_bad++; $display("FAIL word_read_moc_drop got %b want 0", ma); end
  endtask

  task automatic test_byte_half_read();
    int lat; logic ma;
    xfer(1'b1, 2'b00, 9'd9, 32'h0, lat, ma);
    n_cmp++; if (data_out !== 32'h000000AD) begin n_bad++; $display("FAIL byte_read_9 got %h want 000000ad", data_out); end
    xfer(1'b1, 2'b01, 9'd11, 32'h0, lat, ma);
    n_cmp++; if (data_out !== 32'h0000BEEF) begin n_bad++; $display("FAIL half_read_11 got %h want 0000beef", data_out); end
  endtask

  task automatic test_half_write();
    int lat; logic ma;
    xfer(1'b0, 2'b01, 9'd12, 32'hFFFF1234, lat, ma);
    n_cmp++; if (dut.memory[12] !== 8'h12) begin n_bad++; $display("FAIL half_wr_m12 got %h want 12", dut.memory[12]); end
    n_cmp++; if (dut.memory[13] !== 8'h34) begin n_bad++; $display("FAIL half_wr_m13 got %h want 34", dut.memory[13]); end
    n_cmp++; if (dut.memory[14] !== 8'hCC) begin n_bad++; $display("FAIL half_wr_m14 got %h want cc", dut.memory[14]); end
    n_cmp++; if (dut.memory[15] !== 8'hDD) begin n_bad++; $display("FAIL half_wr_m15 got %h want dd", dut.memory[15]); end
    n_cmp++; if (data_out !== 32'h0000BEEF) begin n_bad++; $display("FAIL half_wr_dout got %h want 0000beef", data_out); end
  endtask

  task automatic test_word_write();
    int lat; logic ma;
    xfer(1'b0, 2'b10, 9'h00B, 32'h01020304, lat, ma);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL word_wr_latency got %0d want 3", lat); end
    n_cmp++; if ({dut.memory[8], dut.memory[9], dut.memory[10], dut.memory[11]} !== 32'h01020304) begin
      n_bad++; $display("FAIL word_wr_mem got %h%h%h%h want 01020304",
                        dut.memory[8], dut.memory[9], dut.memory[10], dut.memory[11]);
    end
    xfer(1'b1, 2'b11, 9'd8, 32'h0, lat, ma);
    n_cmp++; if (data_out !== 32'h01020304) begin n_bad++; $display("FAIL word_rd_back got %h want 01020304", data_out); end
  endtask

  task automatic test_top_byte();
    int lat; logic ma;
    xfer(1'b0, 2'b00, 9'd511, 32'h0000005A, lat, ma);
    xfer(1'b1, 2'b00, 9'd511, 32'h0, lat, ma);
    n_cmp++; if (data_out !== 32'h0000005A) begin n_bad++; $display("FAIL top_byte_read got %h want 0000005a", data_out); end
    n_cmp++; if (dut.memory[0] !== 8'h77) begin n_bad++; $display("FAIL top_byte_m0 got %h want 77", dut.memory[0]); end
  endtask

  task automatic test_early_drop();
    int lat;
    mfa = 1'b1; rw = 1'b1; mode = 2'b10; address = 9'd12; data_in = '0;
    @(posedge main_clk); #1;
    mfa = 1'b0;
    lat = 1;
    while (!moc && lat < 20) begin
      @(posedge main_clk); #1;
      lat++;
    end
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL early_drop_latency got %0d want 3", lat); end
    n_cmp++; if (data_out !== 32'h1234CCDD) begin n_bad++; $display("FAIL early_drop_data got %h want 1234ccdd", data_out); end
    @(posedge main_clk); #1;
    n_cmp++; if (moc !== 1'b0) begin n_bad++; $display("FAIL early_drop_one_cycle got %b want 0", moc); end
  endtask

  task automatic test_reset_mid();
    int lat; logic ma;
    mfa = 1'b1; rw = 1'b0; mode = 2'b10; address = 9'd16; data_in = 32'hCAFEF00D;
    @(posedge main_clk); #1;
    @(posedge main_clk); #1;
    n_cmp++; if (moc !== 1'b0) begin n_bad++; $display("FAIL mid_wait_moc got %b want 0", moc); end
    reset = 1'b0;
    #1;
    n_cmp++; if (moc !== 1'b0) begin n_bad++; $display("FAIL mid_reset_moc got %b want 0", moc); end
    n_cmp++; if (data_out !== 32'h0) begin n_bad++; $display("FAIL mid_reset_data got %h want 00000000", data_out); end
    mfa = 1'b0;
    @(posedge main_clk); #1;
    n_cmp++; if ({dut.memory[16], dut.memory[17], dut.memory[18], dut.memory[19]} !== 32'h11223344) begin
      n_bad++; $display("FAIL mid_reset_mem got %h%h%h%h want 11223344",
                        dut.memory[16], dut.memory[17], dut.memory[18], dut.memory[19]);
    end
    reset = 1'b1;
    xfer(1'b1, 2'b10, 9'd16, 32'h0, lat, ma);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL post_reset_latency got %0d want 3", lat); end
    n_cmp++; if (data_out !== 32'h11223344) begin n_bad++; $display("FAIL post_reset_read got %h want 11223344", data_out); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    preload();
    test_word_read();
    test_byte_half_read();
    test_half_write();
    test_word_write();
    test_top_byte();
    test_early_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
